// File: rtl/wb_arbiter.sv
// Two-source writeback arbiter: ALU path (A) and load-return path (B) share one
// register-file write port, alternating on conflict, with a pending-write scoreboard.
module wb_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic       a_valid,
  input  logic [1:0] a_rd,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [1:0] b_rd,
  input  logic [7:0] b_data,
  output logic       b_ready,
  input  logic       issue_valid,
  input  logic [1:0] issue_rd,
  input  logic [1:0] query_rd,
  output logic       query_busy,
  output logic       wr_en,
  output logic [1:0] wr_rd,
  output logic [7:0] wr_data,
  output logic       err
);

  logic       last_grant_reg;
  logic       grant_lg;
  logic       xfer_a;
  logic       xfer_b;
  logic       xfer;
  logic [1:0] xfer_rd;
  logic [7:0] xfer_data;
  logic       wr_en_reg;
  logic [1:0] wr_rd_reg;
  logic [7:0] wr_data_reg;
  logic       err_reg;
  logic [3:0] fault;
  logic [3:0][1:0] counts;

  // While reset is held the arbiter already behaves as if B was granted last.
  assign grant_lg  = reset | last_grant_reg;
  assign a_ready   = a_valid && (!b_valid || grant_lg);
  assign b_ready   = b_valid && (!a_valid || !grant_lg);
  assign xfer_a    = a_valid && a_ready;
  assign xfer_b    = b_valid && b_ready;
  assign xfer      = xfer_a || xfer_b;
  assign xfer_rd   = xfer_b ? b_rd : a_rd;
  assign xfer_data = xfer_b ? b_data : a_data;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sb
      logic       inc;
      logic       dec;
      logic [1:0] cnt_reg;
      logic [1:0] cnt_next;
      logic       fault_next;

      assign inc = issue_valid && (issue_rd == 2'(gi));
      assign dec = xfer && (xfer_rd == 2'(gi));

      // Saturate at both ends; a same-edge issue and retire cancel out.
      always_comb begin
        cnt_next   = cnt_reg;
        fault_next = 1'b0;
        if (inc && !dec) begin
          if (cnt_reg == 2'd3) fault_next = 1'b1;
          else                 cnt_next   = cnt_reg + 2'd1;
        end else if (dec && !inc) begin
          if (cnt_reg == 2'd0) fault_next = 1'b1;
          else                 cnt_next   = cnt_reg - 2'd1;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) cnt_reg <= 2'd0;
        else       cnt_reg <= cnt_next;
      end

      assign counts[gi] = cnt_reg;
      assign fault[gi]  = fault_next;
    end
  endgenerate

  assign query_busy = (counts[query_rd] != 2'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en_reg      <= 1'b0;
      wr_rd_reg      <= 2'd0;
      wr_data_reg    <= 8'd0;
      last_grant_reg <= 1'b1;
      err_reg        <= 1'b0;
    end else begin
      wr_en_reg <= xfer;
      if (xfer) begin
        wr_rd_reg      <= xfer_rd;
        wr_data_reg    <= xfer_data;
        last_grant_reg <= xfer_b;
      end
      if (|fault) err_reg <= 1'b1;
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_rd   = wr_rd_reg;
  assign wr_data = wr_data_reg;
  assign err     = err_reg;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 clock  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising edge of clock.
REQ-003 a_valid  in  1  ALU-path writeback request.
REQ-004 a_rd  in  2  ALU-path destination register.
REQ-005 a_data  in  8  ALU-path write data.
REQ-006 a_ready  out  1  combinational grant to ALU path; a transfer occurs when a_valid && a_ready.
REQ-007 b_valid  in  1  memory-path (load return) writeback request.
REQ-008 b_rd  in  2  memory-path destination register.
REQ-009 b_data  in  8  memory-path write data.
REQ-010 b_ready  out  1  combinational grant to memory path; a transfer occurs when b_valid && b_ready.
REQ-011 issue_valid  in  1  an instruction writing issue_rd was issued; marks the register pending.
REQ-012 issue_rd  in  2  destination register of the issued instruction.
REQ-013 query_rd  in  2  register read by the issue stage.
REQ-014 query_busy  out  1  combinational; 1 when query_rd has pending writes.
REQ-015 wr_en  out  1  registered register-file write enable.
REQ-016 wr_rd  out  2  registered register-file write address.
REQ-017 wr_data  out  8  registered register-file write data.
REQ-018 err  out  1  sticky scoreboard overflow/underflow flag.

Function
REQ-019 The block SHALL accept at most one transfer per cycle; the register file is never back-pressured.
REQ-020 Only a_valid=1: a_ready=1, b_ready=0. Only b_valid=1: b_ready=1, a_ready=0. Neither: both readies 0.
REQ-021 Both valid: grant goes to the source not recorded in last_grant; the loser's ready is 0 and it holds valid, rd, and data stable until granted.
REQ-022 last_grant (1 bit, A=0/B=1) SHALL update to the granted source on every transfer, whether or not a conflict existed.
REQ-023 A transfer accepted at edge N SHALL appear at wr_en=1, wr_rd, wr_data during cycle N+1 (latency 1); with no transfer at N, wr_en=0 in cycle N+1 and wr_rd/wr_data hold their previous values.
REQ-024 The scoreboard SHALL hold a 2-bit pending count per register (4 counts).
REQ-025 issue_valid at an edge SHALL increment count[issue_rd].
REQ-026 A transfer at an edge SHALL decrement count[rd of granted source] at that same edge.
REQ-027 Issue and transfer to the same register at the same edge SHALL leave the count unchanged; to different registers, both updates SHALL apply.
REQ-028 Issue to a register whose count is 3 (without a simultaneous transfer to it) SHALL leave the count at 3 and set err.
REQ-029 A transfer to a register whose count is 0 (without a simultaneous issue to it) SHALL leave the count at 0, set err, and still write the register file.
REQ-030 query_busy SHALL equal (count[query_rd] != 0); it reflects register state only and ignores same-cycle issue_valid.
REQ-031 err SHALL remain 1 until reset.

Reset
REQ-032 When reset=1 at an edge: wr_en=0, wr_rd=0, wr_data=0, err=0, all counts=0, last_grant=B (1), so A wins the first conflict.
REQ-033 While reset=1, transfers and issues sampled at that edge SHALL be discarded; readies SHALL still follow REQ-020/021 from the reset state of last_grant.
REQ-034 Reset during a held (losing) request SHALL not drop it at the interface; it is granted after reset per REQ-020/021.

Verification
REQ-035 Reset, then a_valid=1 a_rd=2 a_data=0x5A -> a_ready=1 the same cycle; next cycle wr_en=1 wr_rd=2 wr_data=0x5A; the cycle after, wr_en=0.
REQ-036 After reset, a_valid=b_valid=1 for 3 cycles (A rd=1 0x11, B rd=3 0x33, each source dropping valid once served, then re-asserting) -> grants A, B, A; wr_data sequence 0x11, 0x33, 0x11.
REQ-037 issue_valid rd=0 twice -> query_rd=0 gives query_busy=1; two transfers to rd=0 -> query_busy=0 after the second edge; err=0.
REQ-038 count[1]=1, with issue_valid rd=1 and a transfer to rd=1 at the same edge -> count[1] stays 1, query_busy=1, err=0.
REQ-039 Four issues to rd=3 -> err=1 after the fourth edge, count stays 3; separately, a transfer to idle rd=0 -> err=1, wr_en=1 next cycle.
REQ-040 Assert reset while B is held losing with counts nonzero -> counts=0 and err=0 after the edge; B is granted on the first post-reset cycle when A is idle.
